adc_chain: RTL and testbench
============================

// Module: adc_chain
// PURPOSE
// Receive front end: drives the ADC sample clock, captures 16-bit real ADC samples and mixes them to
// baseband with an NCO (digital down-conversion). Decimates I/Q by integrate-and-dump and emits
// {Q,I} on an AXI-Stream master toward the OFDM demodulator. Single clock domain.
// PARAMETERS
// ADC_CLK_DIV  4   aclk cycles per ADC sample; even, >=2
// LUT_AW       10  sine LUT address bits (2^LUT_AW entries over one full cycle)
// PORTS
// aclk            in   1   system clock; all logic on rising edge
// areset          in   1   synchronous, active-high reset
// ADC_control     in   4   [0] enable; [1] 1 = ADCdata is offset-binary (invert MSB); [3:2] reserved
// ADCdata         in   16  ADC sample bus, two's complement unless ADC_control[1]
// ClockToADC      out  1   ADC sample clock, aclk/ADC_CLK_DIV, 50% duty
// Fc_scaled       in   32  NCO phase increment per ADC sample = round(f_mix*2^32/f_sample)
// decimate_ratio  in   16  samples per output (0 and 1 both mean 1)
// M_AXIS_tdata    out  32  [15:0] I, [31:16] Q, signed
// M_AXIS_tvalid   out  1   output valid
// M_AXIS_tready   in   1   downstream ready
// status          out  32  [0] enable, [1] overflow sticky, [15:2] 0, [31:16] output count (wraps)
// BEHAVIOUR
// - Reset: div_cnt=0, ClockToADC=0, phase=0, accumulators/sample counter=0, M_AXIS_tvalid=0,
//   M_AXIS_tdata=0, status=0. ClockToADC toggles regardless of enable.
// - div_cnt counts 0..ADC_CLK_DIV-1; ClockToADC registered = (div_cnt >= ADC_CLK_DIV/2).
//   Sample strobe on cycles with div_cnt==0: ADCdata registered as x (MSB inverted if ADC_control[1]).
// - NCO: 32-bit phase, advances by Fc_scaled after each strobe (wraps mod 2^32); the first strobe after
//   enable uses phase 0. Fc_scaled is sampled per strobe (new value applies at the next strobe).
// - LUT: entry k = round(32767*sin(2*pi*k/2^LUT_AW)); sin = LUT[phase[31:32-LUT_AW]],
//   cos = LUT[that address + 2^(LUT_AW-2)]. ROM, 1-cycle registered read.
// - Mixer: pI = (x*cos)>>>15, pQ = (x*(-sin))>>>15; 32-bit signed product, arithmetic shift (floor),
//   result fits 16 bits, no saturation needed. Products registered.
// - Decimator: 48-bit signed accumulators; N = max(decimate_ratio,1), latched at block start.
//   After N products: out = sat16(sum >>> ceil(log2(N))); accumulators restart with the next product.
// - Latency: output valid exactly 3 aclk cycles after the strobe edge that captured the block's last sample.
// - Handshake: tdata/tvalid held stable until tvalid&&tready. A new result arriving while tvalid&&!tready
//   is discarded and status[1] is set (sticky until reset or enable=0). Simultaneous handshake and new
//   result: new result loads, tvalid stays 1.
// - status[31:16] increments on every accepted transfer.
// - enable=0: phase, accumulators, block counter, pipeline valids cleared, status[1] cleared. A pending
//   output still completes its handshake. Asserting enable starts a fresh block at the next strobe.
// - Reset mid-block: partial sums are discarded and no output is produced for that block.
// TESTING
// - DC x=1000, Fc=0, N=4 -> each output I=999, Q=0; one output every 4*ADC_CLK_DIV cycles.
// - DC x=1000, Fc=0, N=160 -> I=159840>>>8=624, Q=0 (non-power-of-2 gain check).
// - x=1000, Fc=2^30, N=4 -> pI = 999,0,-1000,0 and pQ = 0,-1000,0,999; output I=-1, Q=-1.
// - ADC_control[1]=1, ADCdata=16'h8000 + 1000, Fc=0, N=1 -> I=999 every strobe;
//   tvalid exactly 3 cycles after the strobe.
// - tready=0 over two block completions -> first result held; second dropped; status[1]=1;
//   status[31:16] unchanged until tready=1.
// - areset or enable=0 mid-block -> no partial output; the next block starts with phase 0 and
//   matches the first scenario.

Source files
------------

// File: rtl/adc_chain.sv
// adc_chain: receive front end. Generates the ADC sample clock, captures real
// ADC samples, mixes them to baseband with an NCO, decimates I/Q by
// integrate-and-dump and streams {Q,I} on an AXI-Stream master.
//
// Ports:
//   aclk, areset    system clock, synchronous active-high reset
//   ADC_control     [0] enable, [1] offset-binary input (invert MSB), [3:2] reserved
//   ADCdata         16-bit ADC sample bus
//   ClockToADC      ADC sample clock, aclk/ADC_CLK_DIV, 50% duty
//   Fc_scaled       NCO phase increment per ADC sample
//   decimate_ratio  samples per output (0 and 1 both mean 1)
//   M_AXIS_*        output stream, tdata = {Q[15:0], I[15:0]}
//   status          [0] enable, [1] overflow sticky, [31:16] accepted output count
module adc_chain #(
  parameter int ADC_CLK_DIV = 4,
  parameter int LUT_AW      = 10
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [3:0]  ADC_control,
  input  logic [15:0] ADCdata,
  output logic        ClockToADC,
  input  logic [31:0] Fc_scaled,
  input  logic [15:0] decimate_ratio,
  output logic [31:0] M_AXIS_tdata,
  output logic        M_AXIS_tvalid,
  input  logic        M_AXIS_tready,
  output logic [31:0] status
);

  localparam int DIV_W = (ADC_CLK_DIV > 2) ? $clog2(ADC_CLK_DIV) : 1;
  localparam int LUT_N = 2 ** LUT_AW;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(ADC_CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF = DIV_W'(ADC_CLK_DIV / 2);
  localparam logic [LUT_AW-1:0] QUARTER  = LUT_AW'(LUT_N / 4);

  function automatic logic [4:0] ceil_log2(input logic [15:0] n);
    logic [4:0] s;
    s = '0;
    for (int unsigned i = 0; i < 16; i++)
      if ((17'd1 << i) < {1'b0, n}) s = 5'(i + 1);
    return s;
  endfunction

  function automatic logic [15:0] sat16(input logic signed [47:0] v);
    if (v > 48'sd32767)       return 16'h7FFF;
    else if (v < -48'sd32768) return 16'h8000;
    else                      return v[15:0];
  endfunction

  logic enable;
  assign enable = ADC_control[0];

  // Sample clock divider; runs independently of enable.
  logic [DIV_W-1:0] div_cnt;
  logic             strobe;
  assign strobe = (div_cnt == '0);

  always_ff @(posedge aclk) begin
    if (areset) begin
      div_cnt    <= '0;
      ClockToADC <= 1'b0;
    end else begin
      div_cnt    <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      ClockToADC <= (div_cnt >= DIV_HALF);
    end
  end

  // Sine ROM, one full cycle, contents fixed at elaboration.
  logic signed [15:0] lut [0:LUT_N-1];
  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    localparam real ANG = 2.0 * 3.14159265358979323846 * k / LUT_N;
    localparam int  VAL = int'(32767.0 * $sin(ANG));
    assign lut[k] = 16'(VAL);
  end

  // Stage 0: sample capture, NCO lookup, phase advance.
  logic [31:0]        phase;
  logic [LUT_AW-1:0]  sin_addr, cos_addr;
  logic signed [15:0] x_r, sin_r, cos_r;
  logic               s_valid;

  assign sin_addr = phase[31 -: LUT_AW];
  assign cos_addr = sin_addr + QUARTER;

  always_ff @(posedge aclk) begin
    if (areset || !enable) begin
      phase   <= '0;
      s_valid <= 1'b0;
    end else begin
      s_valid <= strobe;
      if (strobe) phase <= phase + Fc_scaled;
    end
  end

  always_ff @(posedge aclk) begin
    if (strobe) begin
      x_r   <= {ADCdata[15] ^ ADC_control[1], ADCdata[14:0]};
      sin_r <= lut[sin_addr];
      cos_r <= lut[cos_addr];
    end
  end

  // Stage 1: mixer; >>>15 of the 32-bit product is bits [30:15].
  logic signed [31:0] prod_i, prod_q;
  logic signed [15:0] p_i, p_q;
  logic               p_valid;

  assign prod_i = 32'(x_r) * 32'(cos_r);
  assign prod_q = -(32'(x_r) * 32'(sin_r));

  always_ff @(posedge aclk) begin
    if (areset || !enable) p_valid <= 1'b0;
    else                   p_valid <= s_valid;
    p_i <= prod_i[30:15];
    p_q <= prod_q[30:15];
  end

  // Stage 2: integrate-and-dump. N and its shift are latched by the first
  // product of a block; that product uses the live values directly.
  logic signed [47:0] acc_i, acc_q, sum_i, sum_q, res_i, res_q;
  logic [15:0]        blk_cnt, n_lat, n_now, n_use;
  logic [4:0]         sh_lat, sh_now, sh_use, res_sh;
  logic               last, res_valid;

  assign n_now  = (decimate_ratio == '0) ? 16'd1 : decimate_ratio;
  assign sh_now = ceil_log2(n_now);
  assign n_use  = (blk_cnt == '0) ? n_now : n_lat;
  assign sh_use = (blk_cnt == '0) ? sh_now : sh_lat;
  assign last   = ((blk_cnt + 16'd1) == n_use);
  assign sum_i  = ((blk_cnt == '0) ? '0 : acc_i) + {{32{p_i[15]}}, p_i};
  assign sum_q  = ((blk_cnt == '0) ? '0 : acc_q) + {{32{p_q[15]}}, p_q};

  always_ff @(posedge aclk) begin
    if (areset || !enable) begin
      acc_i     <= '0;
      acc_q     <= '0;
      blk_cnt   <= '0;
      n_lat     <= 16'd1;
      sh_lat    <= '0;
      res_valid <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      if (p_valid) begin
        if (blk_cnt == '0) begin
          n_lat  <= n_now;
          sh_lat <= sh_now;
        end
        if (last) begin
          res_i     <= sum_i;
          res_q     <= sum_q;
          res_sh    <= sh_use;
          res_valid <= 1'b1;
          acc_i     <= '0;
          acc_q     <= '0;
          blk_cnt   <= '0;
        end else begin
          acc_i   <= sum_i;
          acc_q   <= sum_q;
          blk_cnt <= blk_cnt + 16'd1;
        end
      end
    end
  end

  // Stage 3: scale, saturate, AXI-Stream output register.
  logic signed [47:0] sh_i, sh_q;
  logic               ovf, en_r;
  logic [15:0]        out_cnt;

  assign sh_i = res_i >>> res_sh;
  assign sh_q = res_q >>> res_sh;

  always_ff @(posedge aclk) begin
    if (areset) begin
      M_AXIS_tdata  <= '0;
      M_AXIS_tvalid <= 1'b0;
      ovf           <= 1'b0;
      out_cnt       <= '0;
      en_r          <= 1'b0;
    end else begin
      en_r <= enable;
      if (M_AXIS_tvalid && M_AXIS_tready) out_cnt <= out_cnt + 16'd1;
      // A result still in flight when enable drops is discarded here.
      if (res_valid && enable) begin
        if (!M_AXIS_tvalid || M_AXIS_tready) begin
          M_AXIS_tdata  <= {sat16(sh_q), sat16(sh_i)};
          M_AXIS_tvalid <= 1'b1;
        end else begin
          ovf <= 1'b1;
        end
      end else if (M_AXIS_tvalid && M_AXIS_tready) begin
        M_AXIS_tvalid <= 1'b0;
      end
      if (!enable) ovf <= 1'b0;
    end
  end

  assign status = {out_cnt, 14'd0, ovf, en_r};

  logic unused_bits;
  assign unused_bits = ^{ADC_control[3:2], prod_i[31], prod_i[14:0],
                         prod_q[31], prod_q[14:0]};

endmodule

// File: tb/tb_adc_chain.sv
module tb_adc_chain;

  logic        aclk = 1'b0;
  logic        areset;
  logic [3:0]  ADC_control;
  logic [15:0] ADCdata;
  logic        ClockToADC;
  logic [31:0] Fc_scaled;
  logic [15:0] decimate_ratio;
  logic [31:0] M_AXIS_tdata;
  logic        M_AXIS_tvalid;
  logic        M_AXIS_tready;
  logic [31:0] status;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  always #5 aclk = ~aclk;

  adc_chain #(.ADC_CLK_DIV(4), .LUT_AW(10)) dut (
    .aclk(aclk), .areset(areset), .ADC_control(ADC_control), .ADCdata(ADCdata),
    .ClockToADC(ClockToADC), .Fc_scaled(Fc_scaled), .decimate_ratio(decimate_ratio),
    .M_AXIS_tdata(M_AXIS_tdata), .M_AXIS_tvalid(M_AXIS_tvalid),
    .M_AXIS_tready(M_AXIS_tready), .status(status)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic wait_valid(input int budget, output int cycles);
    cycles = 0;
    while (!M_AXIS_tvalid && cycles < budget) begin
      tick(1);
      cycles++;
    end
  endtask

  task automatic test_reset;
    areset = 1'b1;
    ADC_control = 4'd0;
    tick(3);
    n_checks++;
    if (M_AXIS_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b want 0", M_AXIS_tvalid); end
    n_checks++;
    if (M_AXIS_tdata !== 32'd0) begin n_fail++; $display("FAIL reset_tdata: got %h want 0", M_AXIS_tdata); end
    n_checks++;
    if (status !== 32'd0) begin n_fail++; $display("FAIL reset_status: got %h want 0", status); end
    n_checks++;
    if (ClockToADC !== 1'b0) begin n_fail++; $display("FAIL reset_adcclk: got %b want 0", ClockToADC); end
    areset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      n_checks++;
      if (ClockToADC !== ((i % 4) >= 2)) begin
        n_fail++;
        $display("FAIL adcclk_pattern[%0d]: got %b want %b", i, ClockToADC, (i % 4) >= 2);
      end
    end
  endtask

  task automatic test_dc_n4;
    int c;
    ADCdata = 16'd1000; Fc_scaled = 32'd0; decimate_ratio = 16'd4; ADC_control = 4'b0001;
    wait_valid(60, c);
    n_checks++;
    if (M_AXIS_tvalid !== 1'b1) begin n_fail++; $display("FAIL dc_n4_timeout: tvalid %b want 1", M_AXIS_tvalid); end
    n_checks++;
    if (M_AXIS_tdata !== 32'h0000_03E7) begin n_fail++; $display("FAIL dc_n4_first: got %h want 000003e7", M_AXIS_tdata); end
    n_checks++;
    if (status[0] !== 1'b1) begin n_fail++; $display("FAIL status_enable: got %b want 1", status[0]); end
    tick(1);
    exp_cnt++;
    n_checks++;
    if (status[31:16] !== 16'(exp_cnt)) begin n_fail++; $display("FAIL dc_n4_count: got %0d want %0d", status[31:16], exp_cnt); end
    n_checks++;
    if (M_AXIS_tvalid !== 1'b0) begin n_fail++; $display("FAIL dc_n4_drop: tvalid %b want 0", M_AXIS_tvalid); end
    wait_valid(30, c);
    n_checks++;
    if (M_AXIS_tvalid !== 1'b1 || c + 1 != 16) begin
      n_fail++; $display("FAIL dc_n4_period: got %0d cycles want 16", c + 1);
    end
    n_checks++;
    if (M_AXIS_tdata !== 32'h0000_03E7) begin n_fail++; $display("FAIL dc_n4_second: got %h want 000003e7", M_AXIS_tdata); end
    tick(1);
    exp_cnt++;
    ADC_control = 4'b0000;
    tick(4);
  endtask

  task automatic test_gain_n160;
    int c;
    ADCdata = 16'd1000; Fc_scaled = 32'd0; decimate_ratio = 16'd160; ADC_control = 4'b0001;
    wait_valid(800, c);
    n_checks++;
    if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== 32'h0000_0270) begin
      n_fail++; $display("FAIL gain_n160: got v=%b %h want 1 00000270", M_AXIS_tvalid, M_AXIS_tdata);
    end
    tick(1);
    exp_cnt++;
    ADC_control = 4'b0000;
    tick(4);
  endtask

  task automatic test_quadrature;
    int c;
    ADCdata = 16'd1000; Fc_scaled = 32'h4000_0000; decimate_ratio = 16'd4; ADC_control = 4'b0001;
    for (int b = 0; b < 2; b++) begin
      wait_valid(60, c);
      n_checks++;
      if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== 32'hFFFF_FFFF) begin
        n_fail++; $display("FAIL quad_block%0d: got v=%b %h want 1 ffffffff", b, M_AXIS_tvalid, M_AXIS_tdata);
      end
      tick(1);
      exp_cnt++;
    end
    ADC_control = 4'b0000;
    tick(4);
    n_checks++;
    if (status[31:16] !== 16'(exp_cnt)) begin n_fail++; $display("FAIL quad_count: got %0d want %0d", status[31:16], exp_cnt); end
  endtask

  task automatic test_offset_latency;
    logic ck [0:24];
    logic tv [0:24];
    int rises = 0;
    ADCdata = 16'h83E8; Fc_scaled = 32'd0; decimate_ratio = 16'd0; ADC_control = 4'b0011;
    ck[0] = ClockToADC;
    tv[0] = M_AXIS_tvalid;
    for (int i = 1; i <= 24; i++) begin
      tick(1);
      ck[i] = ClockToADC;
      tv[i] = M_AXIS_tvalid;
      if (tv[i] && !tv[i-1]) begin
        rises++;
        n_checks++;
        if (i < 4 || ck[i-3] !== 1'b0 || ck[i-4] !== 1'b1) begin
          n_fail++; $display("FAIL ob_latency: tvalid at edge %0d not 3 after strobe", i);
        end
        n_checks++;
        if (M_AXIS_tdata !== 32'h0000_03E7) begin n_fail++; $display("FAIL ob_data: got %h want 000003e7", M_AXIS_tdata); end
      end
    end
    n_checks++;
    if (rises < 5) begin n_fail++; $display("FAIL ob_rate: got %0d outputs want >=5", rises); end
    ADC_control = 4'b0000;
    tick(4);
    exp_cnt += rises;
    n_checks++;
    if (status[31:16] !== 16'(exp_cnt)) begin n_fail++; $display("FAIL ob_count: got %0d want %0d", status[31:16], exp_cnt); end
  endtask

  task automatic test_backpressure;
    int c;
    ADCdata = 16'd1000; Fc_scaled = 32'h4000_0000; decimate_ratio = 16'd1;
    M_AXIS_tready = 1'b0; ADC_control = 4'b0001;
    wait_valid(30, c);
    n_checks++;
    if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== 32'h0000_03E7) begin
      n_fail++; $display("FAIL bp_first: got v=%b %h want 1 000003e7", M_AXIS_tvalid, M_AXIS_tdata);
    end
    tick(6);
    n_checks++;
    if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== 32'h0000_03E7) begin
      n_fail++; $display("FAIL bp_hold: got v=%b %h want 1 000003e7", M_AXIS_tvalid, M_AXIS_tdata);
    end
    n_checks++;
    if (status[1] !== 1'b1) begin n_fail++; $display("FAIL bp_overflow: got %b want 1", status[1]); end
    n_checks++;
    if (status[31:16] !== 16'(exp_cnt)) begin n_fail++; $display("FAIL bp_count_held: got %0d want %0d", status[31:16], exp_cnt); end
    ADC_control = 4'b0000;
    tick(1);
    n_checks++;
    if (status[1] !== 1'b0 || M_AXIS_tvalid !== 1'b1) begin
      n_fail++; $display("FAIL bp_disable: got ovf=%b v=%b want 0 1", status[1], M_AXIS_tvalid);
    end
    M_AXIS_tready = 1'b1;
    tick(1);
    exp_cnt++;
    n_checks++;
    if (M_AXIS_tvalid !== 1'b0 || status[31:16] !== 16'(exp_cnt)) begin
      n_fail++; $display("FAIL bp_accept: got v=%b cnt=%0d want 0 %0d", M_AXIS_tvalid, status[31:16], exp_cnt);
    end
    tick(4);
  endtask

  task automatic test_abort;
    int c;
    bit seen;
    // enable dropped mid-block, then a fresh quadrature block
    ADCdata = 16'd1000; Fc_scaled = 32'h4000_0000; decimate_ratio = 16'd4; ADC_control = 4'b0001;
    seen = 0;
    for (int i = 0; i < 9; i++) begin tick(1); if (M_AXIS_tvalid) seen = 1; end
    ADC_control = 4'b0000;
    for (int i = 0; i < 20; i++) begin tick(1); if (M_AXIS_tvalid) seen = 1; end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL abort_en_partial: got output want none"); end
    ADC_control = 4'b0001;
    wait_valid(60, c);
    n_checks++;
    if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL abort_en_restart: got v=%b %h want 1 ffffffff", M_AXIS_tvalid, M_AXIS_tdata);
    end
    tick(1);
    ADC_control = 4'b0000;
    tick(4);
    // reset mid-block, then a fresh DC block
    Fc_scaled = 32'd0; ADC_control = 4'b0001;
    seen = 0;
    for (int i = 0; i < 9; i++) begin tick(1); if (M_AXIS_tvalid) seen = 1; end
    areset = 1'b1;
    tick(2);
    areset = 1'b0;
    exp_cnt = 0;
    for (int i = 0; i < 10; i++) begin tick(1); if (M_AXIS_tvalid) seen = 1; end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL abort_rst_partial: got output want none"); end
    n_checks++;
    if (status[31:16] !== 16'd0) begin n_fail++; $display("FAIL abort_rst_count: got %0d want 0", status[31:16]); end
    wait_valid(60, c);
    n_checks++;
    if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== 32'h0000_03E7) begin
      n_fail++; $display("FAIL abort_rst_restart: got v=%b %h want 1 000003e7", M_AXIS_tvalid, M_AXIS_tdata);
    end
    tick(1);
    exp_cnt++;
    n_checks++;
    if (status[31:16] !== 16'(exp_cnt)) begin n_fail++; $display("FAIL abort_rst_accept: got %0d want %0d", status[31:16], exp_cnt); end
    ADC_control = 4'b0000;
    tick(4);
  endtask

  initial begin
    areset = 1'b1;
    ADC_control = 4'd0;
    ADCdata = 16'd0;
    Fc_scaled = 32'd0;
    decimate_ratio = 16'd1;
    M_AXIS_tready = 1'b1;
    test_reset();
    test_dc_n4();
    test_gain_n160();
    test_quadrature();
    test_offset_latency();
    test_backpressure();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
